// File: rtl/counter_table_updater.sv
// counter_table_updater: pipelined read-modify-write of saturating 8-bit counters in a byte-write dual-port RAM.
module counter_table_updater #(
    parameter int NUM_COL    = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int STEP       = 4,
    localparam int DATA_WIDTH = NUM_COL * 8,
    localparam int COL_W      = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [COL_W-1:0]      in_col,
    input  logic                  in_bit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_old,
    output logic [7:0]            out_new,
    output logic                  ram_ena,
    output logic [NUM_COL-1:0]    ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_dob
);
    logic                  s1_valid_q, out_valid_q, fwd_valid_q, s1_bit_q;
    logic [ADDR_WIDTH-1:0] s1_addr_q, fwd_addr_q;
    logic [COL_W-1:0]      s1_col_q, fwd_col_q;
    logic [7:0]            fwd_data_q, out_old_q, out_new_q;
    logic [7:0]            rd_byte, old_d, new_d;
    logic [8:0]            sum_up, sum_dn;
    logic                  adv, accept, wr, fwd_hit;

    assign adv       = !out_valid_q | out_ready;
    assign accept    = in_valid & adv;
    assign wr        = s1_valid_q & adv;
    assign in_ready  = adv;
    assign ram_enb   = accept;
    assign ram_addrb = in_addr;

    // The previous cycle's write collided with this read's RAM access, so take its data instead
    assign fwd_hit = fwd_valid_q && fwd_addr_q == s1_addr_q && fwd_col_q == s1_col_q;
    assign rd_byte = ram_dob[{s1_col_q, 3'b000} +: 8];
    assign old_d   = fwd_hit ? fwd_data_q : rd_byte;
    assign sum_up  = {1'b0, old_d} + 9'(STEP);
    assign sum_dn  = {1'b0, old_d} - 9'(STEP);
    assign new_d   = s1_bit_q ? (sum_up[8] ? 8'hFF : sum_up[7:0]) : (sum_dn[8] ? 8'h00 : sum_dn[7:0]);

    assign ram_ena   = wr;
    assign ram_wea   = wr ? NUM_COL'(1) << s1_col_q : '0;
    assign ram_addra = s1_addr_q;
    assign ram_dina  = {NUM_COL{new_d}};
    assign out_valid = out_valid_q;
    assign out_old   = out_old_q;
    assign out_new   = out_new_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s1_col_q    <= '0;
            s1_bit_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_old_q   <= 8'h00;
            out_new_q   <= 8'h00;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_col_q   <= '0;
            fwd_data_q  <= 8'h00;
        end else if (adv) begin
            s1_valid_q  <= accept;
            if (accept) begin
                s1_addr_q <= in_addr;
                s1_col_q  <= in_col;
                s1_bit_q  <= in_bit;
            end
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_old_q <= old_d;
                out_new_q <= new_d;
            end
            fwd_valid_q <= wr & accept;
            fwd_addr_q  <= s1_addr_q;
            fwd_col_q   <= s1_col_q;
            fwd_data_q  <= new_d;
        end
    end
endmodule

// File: tb/tb_counter_table_updater.sv
// tb_counter_table_updater: scoreboard bench with a read-first byte-write RAM model behind the updater.
module tb_counter_table_updater;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, in_bit = 1'b0;
    logic [11:0] in_addr = '0;
    logic [1:0]  in_col = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [7:0]  out_old, out_new;
    logic        ram_ena, ram_enb;
    logic [3:0]  ram_wea;
    logic [11:0] ram_addra, ram_addrb;
    logic [31:0] ram_dina, ram_dob;

    logic [31:0] mem [0:4095];
    logic        pl_en = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [31:0] pl_data = '0;
    int          writes = 0;
    int          n_checks = 0, n_fail = 0;
    logic [15:0] exp_q [$];

    counter_table_updater dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_col(in_col), .in_bit(in_bit),
        .out_valid(out_valid), .out_ready(out_ready), .out_old(out_old), .out_new(out_new),
        .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
        .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob)
    );

    always #5 clk = ~clk;

    // Read-first RAM: a read colliding with a same-cycle write returns the stale word
    always @(posedge clk) begin
        if (ram_enb) ram_dob <= mem[ram_addrb];
        if (ram_ena) begin
            writes <= writes + 1;
            for (int i = 0; i < 4; i++)
                if (ram_wea[i]) mem[ram_addra][i*8 +: 8] <= ram_dina[i*8 +: 8];
        end
        if (pl_en) mem[pl_addr] <= pl_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_output", {out_old, out_new}, 32'hDEAD);
            else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("result_old_new", {16'h0, out_old, out_new}, {16'h0, e});
            end
        end
    end

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [11:0] a, input logic [1:0] c, input logic b,
                        input logic [7:0] eo, input logic [7:0] en, input bit push);
        bit done = 0;
        in_valid = 1'b1; in_addr = a; in_col = c; in_bit = b;
        if (push) exp_q.push_back({eo, en});
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        if (!done) chk("accept_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        int wc;
        preload(12'h010, 32'h0000_0080);
        preload(12'h020, 32'h1122_3344);
        preload(12'h030, 32'h0000_00FE);
        preload(12'h031, 32'h0000_0002);
        preload(12'h040, 32'h0000_0000);
        preload(12'h050, 32'h0000_0010);
        chk("reset_ram_ena", {31'h0, ram_ena}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_out_old_new", {16'h0, out_old, out_new}, 32'h0);
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);

        send(12'h010, 2'd0, 1'b1, 8'h80, 8'h84, 1);
        idle(3);
        chk("mem_10_single", mem[12'h010], 32'h0000_0084);

        send(12'h010, 2'd2, 1'b1, 8'h00, 8'h04, 1);
        send(12'h010, 2'd2, 1'b1, 8'h04, 8'h08, 1);
        send(12'h010, 2'd2, 1'b1, 8'h08, 8'h0C, 1);
        idle(3);
        chk("mem_10_forward", mem[12'h010], 32'h000C_0084);

        send(12'h020, 2'd1, 1'b1, 8'h33, 8'h37, 1);
        send(12'h020, 2'd3, 1'b0, 8'h11, 8'h0D, 1);
        idle(3);
        chk("mem_20_two_cols", mem[12'h020], 32'h0D22_3744);

        send(12'h030, 2'd0, 1'b1, 8'hFE, 8'hFF, 1);
        send(12'h030, 2'd0, 1'b1, 8'hFF, 8'hFF, 1);
        send(12'h031, 2'd0, 1'b0, 8'h02, 8'h00, 1);
        idle(3);
        chk("mem_30_sat_hi", mem[12'h030], 32'h0000_00FF);
        chk("mem_31_sat_lo", mem[12'h031], 32'h0000_0000);

        wc = writes;
        out_ready = 1'b0;
        fork
            begin
                send(12'h040, 2'd0, 1'b1, 8'h00, 8'h04, 1);
                send(12'h040, 2'd0, 1'b1, 8'h04, 8'h08, 1);
                send(12'h040, 2'd0, 1'b1, 8'h08, 8'h0C, 1);
                send(12'h040, 2'd0, 1'b1, 8'h0C, 8'h10, 1);
            end
            begin
                bit seen = 0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                if (!seen) chk("stall_wait_timeout", 32'h0, 32'h1);
                for (int k = 0; k < 5; k++) begin
                    chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
                    chk("stall_ram_ena", {31'h0, ram_ena}, 32'h0);
                    chk("stall_ram_enb", {31'h0, ram_enb}, 32'h0);
                    chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
                    chk("stall_out_hold", {16'h0, out_old, out_new}, 32'h0000_0004);
                    @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        chk("stall_write_count", 32'(writes - wc), 32'd4);
        chk("mem_40_stall", mem[12'h040], 32'h0000_0010);

        send(12'h050, 2'd0, 1'b1, 8'h00, 8'h00, 0);
        in_valid = 1'b0;
        wc = writes;
        rst_n = 1'b0;
        #1;
        chk("rst_ram_ena", {31'h0, ram_ena}, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_old_new", {16'h0, out_old, out_new}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_write", 32'(writes - wc), 32'd0);
        chk("mem_50_untouched", mem[12'h050], 32'h0000_0010);
        send(12'h050, 2'd0, 1'b1, 8'h10, 8'h14, 1);
        idle(3);
        chk("mem_50_after_rst", mem[12'h050], 32'h0000_0014);

        idle(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_table_updater.md
Name: counter_table_updater

Overview:
- Read-modify-write initiator for the byte-write dual-port counter RAM.
- Accepts a stream of (address, byte column, bit) update requests.
- For each request: reads the selected 8-bit counter through read port B, then returns the old value downstream.
- Writes back the saturated, stepped value through port A with a one-hot byte-write enable.
- Sustains one update per cycle, including back-to-back hits on the same counter, via a one-deep write forwarding register.

Parameters:
- NUM_COL, 4, byte columns per RAM word.
- ADDR_WIDTH, 12, RAM word address width.
- STEP, 4, counter increment/decrement magnitude (1..255).
- Derived: DATA_WIDTH = NUM_COL*8; COL_W = max(1, clog2(NUM_COL)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_addr  in  ADDR_WIDTH  RAM word address.
- in_col  in  COL_W  byte column within word.
- in_bit  in  1  update direction (1 = up, 0 = down).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_old  out  8  counter value before update.
- out_new  out  8  counter value written back.
- ram_ena  out  1  port A enable.
- ram_wea  out  NUM_COL  port A byte write enables.
- ram_addra  out  ADDR_WIDTH  port A address.
- ram_dina  out  DATA_WIDTH  port A write data.
- ram_enb  out  1  port B enable.
- ram_addrb  out  ADDR_WIDTH  port B address.
- ram_dob  in  DATA_WIDTH  port B read data; valid the cycle after ram_enb, held while ram_enb=0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. rst_n low clears s1_valid, out_valid, fwd_valid and all pipeline registers to 0. out_old/out_new reset to 0x00.
- Upstream holds in_valid low while rst_n is low.
- adv = !out_valid | out_ready; in_ready = adv.
- S0 (combinational):
  - ram_enb = in_valid & adv; ram_addrb = in_addr.
  - On accept, latch addr/col/bit into S1 and set s1_valid; otherwise clear s1_valid when adv.
- S1:
  - byte = ram_dob[s1_col*8 +: 8].
  - If fwd_valid and fwd_addr==s1_addr and fwd_col==s1_col, use fwd_data instead of byte.
  - new = bit ? min(255, old+STEP) : max(0, old-STEP), computed in 9 bits then clamped.
  - When s1_valid & adv: ram_ena=1; ram_wea one-hot at s1_col; ram_addra=s1_addr; ram_dina = new replicated in every column.
  - Same cycle: out_old/out_new load, out_valid set.
  - Otherwise ram_ena=0 and ram_wea=0.
- Forwarding register:
  - On every adv cycle: fwd_valid <= (S1 write this cycle) & (S0 accept this cycle); fwd_addr/col/data <= S1 write addr/col/new.
  - Holds while !adv, because the paired S1 read is also frozen.
  - Covers the one-cycle read-during-write window, where port B read-during-write on a colliding address returns undefined data.
  - Writes two or more cycles older are visible in RAM and need no forwarding.
- Stall (out_valid & !out_ready):
  - No accept, ram_enb=0, ram_ena=0.
  - S1 state, ram_dob and forwarding registers hold; outputs stable.
- Output: out_valid cleared when out_ready & !(s1_valid) on an adv cycle.
- Latency: accept at cycle t → RAM write and out_valid at t+1 (if no stall). Throughput 1/cycle.
- Same address, different column: no forwarding. Byte enables preserve the other bytes.
- Reset mid-operation: in-flight request dropped, no write issued, RAM contents untouched.

Test Plan:
- RAM word 0x10 preloaded 0x00000080; request (0x10, col 0, bit 1), out_ready=1 → out_old=0x80, out_new=0x84 one cycle later; RAM word 0x10 becomes 0x00000084.
- Three back-to-back requests (0x10, col 2, bit 1), initial 0x00 → out_old 0x00, 0x04, 0x08; final RAM byte 2 = 0x0C; the forwarding path is exercised.
- Back-to-back (0x20, col 1, bit 1) then (0x20, col 3, bit 0), word 0x11223344 → results 0x33→0x37 and 0x11→0x0D; final word 0x0D223744.
- Saturation: byte 0xFE with bit 1 → new 0xFF; then 0xFF with bit 1 → 0xFF; byte 0x02 with bit 0 → 0x00.
- Backpressure: out_ready=0 for 5 cycles with in_valid held → in_ready=0, ram_ena=ram_enb=0, outputs stable; on release, remaining same-address updates complete correctly with no lost or duplicate writes.
- rst_n pulsed low with a request in S1 → no ram_ena pulse, out_valid=0, out_old=out_new=0x00; the next request after release reads the unmodified RAM value.
